mem_arb: RTL
============

# mem_arb

Two-requester arbiter sharing the single core memory port between instruction fetch (IF) and load/store (LS). It sits between the fetch and LSU pipeline stages and the downstream memory interface. It keeps one transaction outstanding and routes the response back to its owner. It also drops an in-flight fetch response when the pipeline controller redirects fetch on a jump.

## Interface
Parameters:
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; the write mask is `DATA_W/8` bits
- `MAX_LS_STREAK`, 4, consecutive contested LS grants allowed before IF wins once

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `if_req_valid` in 1: fetch request
- `if_req_addr` in ADDR_W: fetch address
- `if_req_ready` out 1: fetch request accepted this cycle
- `if_rsp_valid` out 1: fetch data valid, one-cycle pulse
- `if_rsp_data` out DATA_W: fetch data
- `flush` in 1: fetch redirect pulse from the pipeline controller
- `ls_req_valid` in 1: load/store request
- `ls_req_we` in 1: 1 = store
- `ls_req_addr` in ADDR_W: load/store address
- `ls_req_wdata` in DATA_W: store data
- `ls_req_wmask` in DATA_W/8: store byte mask
- `ls_req_ready` out 1: load/store request accepted this cycle
- `ls_rsp_valid` out 1: load data valid or store complete, one-cycle pulse
- `ls_rsp_data` out DATA_W: load data
- `mem_req_valid` out 1: downstream request
- `mem_req_ready` in 1: downstream accepts the request
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wmask` out: registered copy of the granted request; IF grants drive `we=0` and `wmask=0`
- `mem_rsp_valid` in 1: downstream response
- `mem_rsp_data` in DATA_W: downstream response data
- `busy` out 1: state is not IDLE

## Operation
- States:
  - IDLE: arbitrate and accept.
  - REQ: drive `mem_req_valid` from the latched request.
  - WAIT: wait for the downstream response.
- Transitions:
  - IDLE→REQ when any request is accepted.
  - REQ→WAIT when `mem_req_ready` is high.
  - WAIT→IDLE when `mem_rsp_valid` is high.
  - All other cases hold the current state.
- Arbitration happens only in IDLE. LS has priority. If `streak == MAX_LS_STREAK` and both requesters are valid, IF wins.
- `if_req_ready = IDLE & ~flush & (IF wins)`. `ls_req_ready = IDLE & (LS wins)`. Both are combinational. At most one is high in any cycle.
- On acceptance, the request fields and the owner are latched. `mem_req_*` outputs are stable from REQ until the handshake completes.
- Streak counter:
  - Increments, saturating at MAX, on an LS grant while `if_req_valid` is high.
  - Clears on any IF grant.
  - Is unchanged by an uncontested LS grant.
- Response routing:
  - `ls_rsp_valid = WAIT & mem_rsp_valid & owner==LS`.
  - `if_rsp_valid = WAIT & mem_rsp_valid & owner==IF & ~drop`.
  - Response data passes through combinationally; outside a valid pulse it is don't-care.
- Flush:
  - In REQ or WAIT with owner IF, `drop` is set. The downstream transaction still completes, and its response is consumed silently.
  - In IDLE, flush blocks IF acceptance that cycle.
  - `drop` clears on entering IDLE.
  - Flush never affects LS transactions.
- Reset, including mid-transaction: state goes to IDLE, and owner, `drop` and streak clear. All outputs go to 0 immediately. Any outstanding downstream transaction is abandoned; the downstream is reset by the same `rst_n`.

## Timing
- Accept at cycle t (IDLE) → `mem_req_valid` at t+1 → if `mem_req_ready` is high at t+1, WAIT at t+2.
- Earliest requester response is t+2, same cycle as `mem_rsp_valid`. IDLE is re-entered at t+3.
- Minimum issue interval is 3 cycles. There is no back-to-back acceptance in the cycle a response returns.
- A `mem_rsp_valid` outside WAIT is ignored.
- A flush coincident with the response cycle in WAIT suppresses that `if_rsp_valid`.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `{IDLE, REQ, WAIT}`
  - owner enum `{OWN_IF, OWN_LS}`
  - a default `MAX_LS_STREAK` constant
- Sub-module `mem_arb_pick`: combinational winner selection from the two valids, the streak count and flush. It has no state.

## Test plan
- IF only: fetch 0x8000_0000, ready at t+1, response 0x13 at t+2 → `if_req_ready`@t, `if_rsp_valid`=1 and `if_rsp_data`=0x13 @t+2, `busy` low @t+3.
- Contention: both valid continuously, downstream zero-wait → grants LS,LS,LS,LS,IF,LS…, and the streak resets after the IF grant.
- Store: LS `we=1`, addr 0x100, `wdata` 0xDEAD_BEEF, `wmask` 0x0F → `mem_req_*` equal these and stay stable over 3 cycles of `mem_req_ready=0`; `ls_rsp_valid` fires once.
- Flush during WAIT of an IF fetch → no `if_rsp_valid` for that response. The next IF fetch at 0x8000_0040 returns normally.
- Flush coinciding with `if_req_valid` in IDLE, LS idle → `if_req_ready=0` that cycle, 1 the next cycle.
- `rst_n` asserted low in WAIT → outputs 0 asynchronously, state IDLE. After release, a new fetch is accepted on the first cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory-port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states; IDLE encodes as zero so a reset FSM reads as 0.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Owner of the single outstanding downstream transaction.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Contested LS grants allowed before IF is forced through once.
  localparam int DEF_MAX_LS_STREAK = 4;

  // Width of a counter that must hold 0..max_streak inclusive.
  function automatic int streak_w(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Stateless winner selection between fetch and load/store.
// LS normally wins; once the LS streak has reached its limit a
// contending fetch wins instead. A flushed fetch does not contend,
// so a flush can never stall a pending LS request.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_LS_STREAK = DEF_MAX_LS_STREAK,
  parameter int SW            = streak_w(MAX_LS_STREAK)
) (
  input  logic          i_if_valid,
  input  logic          i_ls_valid,
  input  logic          i_flush,
  input  logic [SW-1:0] i_streak,
  output logic          o_if_win,
  output logic          o_ls_win
);

  logic w_if_cand;
  logic w_if_turn;

  // Pick at most one winner from the two requesters.
  always_comb begin
    w_if_cand = i_if_valid & ~i_flush;
    w_if_turn = (i_streak == SW'(MAX_LS_STREAK));
    o_ls_win  = i_ls_valid & ~(w_if_cand & w_if_turn);
    o_if_win  = w_if_cand & ~o_ls_win;
  end

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter for the core memory port (fetch vs load/store).
// One transaction outstanding; the response is routed to its owner and
// a fetch response is silently consumed if fetch was redirected.
//
// Handshake: a request transfers on a cycle where valid and ready are
// both high; ready may depend combinationally on valid, valid must not
// depend on ready, and request fields are held until the transfer.
// Responses are single-cycle pulses with no backpressure.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int MAX_LS_STREAK = DEF_MAX_LS_STREAK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                flush,
  input  logic                ls_req_valid,
  input  logic                ls_req_we,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int SW = streak_w(MAX_LS_STREAK);
  localparam int MW = DATA_W / 8;

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic                r_drop;
  logic [SW-1:0]       r_streak;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MW-1:0]       r_wmask;

  logic                w_idle;
  logic                w_if_win;
  logic                w_ls_win;
  logic                w_if_acc;
  logic                w_ls_acc;
  logic                w_rsp_done;

  mem_arb_pick #(
    .MAX_LS_STREAK (MAX_LS_STREAK),
    .SW            (SW)
  ) u_pick (
    .i_if_valid (if_req_valid),
    .i_ls_valid (ls_req_valid),
    .i_flush    (flush),
    .i_streak   (r_streak),
    .o_if_win   (w_if_win),
    .o_ls_win   (w_ls_win)
  );

  // Readies are qualified by rst_n so nothing is accepted while held in reset.
  assign w_idle     = rst_n & (r_state == IDLE);
  assign w_if_acc   = w_idle & w_if_win;
  assign w_ls_acc   = w_idle & w_ls_win;
  assign w_rsp_done = (r_state == WAIT) & mem_rsp_valid;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: accept -> issue -> await response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_if_acc | w_ls_acc) w_state_nxt = REQ;
      REQ:     if (mem_req_ready)       w_state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid)       w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  // Latch the granted request and its owner; fetches never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_ls_acc) begin
      r_owner <= OWN_LS;
      r_we    <= ls_req_we;
      r_addr  <= ls_req_addr;
      r_wdata <= ls_req_wdata;
      r_wmask <= ls_req_wmask;
    end else if (w_if_acc) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= if_req_addr;
      r_wdata <= '0;
      r_wmask <= '0;
    end
  end

  // Count contested LS grants; any fetch grant restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_if_acc) begin
      r_streak <= '0;
    end else if (w_ls_acc && if_req_valid && (r_streak != SW'(MAX_LS_STREAK))) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // Remember a fetch redirect that hit an in-flight fetch; cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (w_rsp_done) begin
      r_drop <= 1'b0;
    end else if (flush && (r_state != IDLE) && (r_owner == OWN_IF)) begin
      r_drop <= 1'b1;
    end
  end

  assign if_req_ready  = w_if_acc;
  assign ls_req_ready  = w_ls_acc;

  assign mem_req_valid = (r_state == REQ);
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

  // A flush in the response cycle itself also suppresses the fetch pulse.
  assign ls_rsp_valid  = w_rsp_done & (r_owner == OWN_LS);
  assign if_rsp_valid  = w_rsp_done & (r_owner == OWN_IF) & ~r_drop & ~flush;
  assign ls_rsp_data   = ls_rsp_valid ? mem_rsp_data : '0;
  assign if_rsp_data   = if_rsp_valid ? mem_rsp_data : '0;

  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;

endmodule
